// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer wrapped around the 4-bit program counter.
// Drives the fetch address, latches and decodes the instruction, and emits counter strobes.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  MainClock,
    input  logic                  MainReset,
    input  logic                  Run,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [DATA_WIDTH-1:0] InstrData,
    output logic [ADDR_WIDTH-1:0] ProgAddr,
    output logic [DATA_WIDTH-1:0] IR,
    output logic                  EnableCount,
    output logic                  ClearCounter,
    output logic                  ExecStrobe,
    output logic                  Halted,
    output logic [2:0]            State
);

    localparam int OPW = DATA_WIDTH - 4;
    localparam logic [OPW-1:0] WAIT_ONE = OPW'(1);
    localparam logic [3:0] OP_WAIT = 4'hD;
    localparam logic [3:0] OP_RST  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    state_e                after_exec;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [OPW-1:0]        wait_q, wait_d;
    logic                  en_q, en_d;
    logic                  clr_q, clr_d;
    logic                  xs_q, xs_d;
    logic                  halt_q, halt_d;
    logic [3:0]            opcode;

    assign opcode = ir_q[DATA_WIDTH-1 -: 4];
    // Dropping Run lets the current instruction finish, then parks in IDLE.
    assign after_exec = Run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        xs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    clr_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                addr_d  = PC;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = InstrData;
                wait_d  = InstrData[OPW-1:0];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_WAIT: begin
                        if (wait_q != '0) begin
                            wait_d = wait_q - WAIT_ONE;
                        end else begin
                            en_d    = 1'b1;
                            xs_d    = 1'b1;
                            state_d = after_exec;
                        end
                    end
                    OP_RST: begin
                        clr_d   = 1'b1;
                        xs_d    = 1'b1;
                        state_d = after_exec;
                    end
                    OP_HALT: begin
                        xs_d    = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        en_d    = 1'b1;
                        xs_d    = 1'b1;
                        state_d = after_exec;
                    end
                endcase
            end
            S_HALT: begin
                if (!Run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        halt_d = (state_d == S_HALT);
    end

    always_ff @(posedge MainClock) begin
        if (MainReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            wait_q  <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            xs_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            xs_q    <= xs_d;
            halt_q  <= halt_d;
        end
    end

    assign ProgAddr     = addr_q;
    assign IR           = ir_q;
    assign EnableCount  = en_q;
    assign ClearCounter = clr_q;
    assign ExecStrobe   = xs_q;
    assign Halted       = halt_q;
    assign State        = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small program memory and a model of the PC counter.
module tb_fetch_sequencer;

    logic       MainClock = 1'b0;
    logic       MainReset;
    logic       Run;
    logic [3:0] PC;
    logic [7:0] InstrData;
    logic [3:0] ProgAddr;
    logic [7:0] IR;
    logic       EnableCount, ClearCounter, ExecStrobe, Halted;
    logic [2:0] State;

    logic [7:0] mem [16];
    logic       force_en;
    logic [7:0] force_val;
    logic [3:0] pc = 4'd7;
    int         n_checks = 0;
    int         n_fail = 0;

    fetch_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .MainClock(MainClock), .MainReset(MainReset), .Run(Run), .PC(PC),
        .InstrData(InstrData), .ProgAddr(ProgAddr), .IR(IR),
        .EnableCount(EnableCount), .ClearCounter(ClearCounter),
        .ExecStrobe(ExecStrobe), .Halted(Halted), .State(State)
    );

    always #5 MainClock = ~MainClock;

    // Counter clocked by the gated strobe: it updates just after the edge that raises a strobe.
    always @(posedge MainClock) begin
        #1;
        if (ClearCounter === 1'b1) pc = 4'd0;
        else if (EnableCount === 1'b1) pc = pc + 4'd1;
    end

    assign PC = pc;
    assign InstrData = force_en ? force_val : mem[ProgAddr];

    task automatic step(input int n);
        repeat (n) @(negedge MainClock);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        MainReset = 1'b1;
        Run = 1'b0;
        step(2);
        MainReset = 1'b0;
        force_en = 1'b0;
    endtask

    task automatic test_reset();
        MainReset = 1'b1; Run = 1'b1; force_en = 1'b1; force_val = 8'hFF;
        fill(8'hFF);
        step(2);
        n_checks++;
        if ({ProgAddr, IR, EnableCount, ClearCounter, ExecStrobe, Halted, State} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0h ir=%0h en=%b clr=%b xs=%b h=%b st=%0d, expected all 0",
                     ProgAddr, IR, EnableCount, ClearCounter, ExecStrobe, Halted, State);
        end
        MainReset = 1'b0;
        step(1);
        n_checks++;
        if (ClearCounter !== 1'b1 || State !== 3'd1 || EnableCount !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got clr=%b st=%0d en=%b, expected clr=1 st=1 en=0",
                     ClearCounter, State, EnableCount);
        end
        step(1);
        n_checks++;
        if (ClearCounter !== 1'b0 || State !== 3'd2 || ProgAddr !== 4'd0 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got clr=%b st=%0d addr=%0h pc=%0h, expected 0 2 0 0",
                     ClearCounter, State, ProgAddr, pc);
        end
    endtask

    task automatic test_nop_stream();
        int pulses, xs, dec, badaddr, both;
        pulses = 0; xs = 0; dec = 0; badaddr = 0; both = 0;
        fill(8'h00);
        do_reset();
        Run = 1'b1;
        for (int s = 1; s <= 31; s++) begin
            step(1);
            if (EnableCount === 1'b1) pulses++;
            if (ExecStrobe === 1'b1) xs++;
            if (EnableCount === 1'b1 && ClearCounter === 1'b1) both++;
            if (State === 3'd2) begin
                if (ProgAddr !== dec[3:0]) badaddr++;
                dec++;
            end
        end
        n_checks++;
        if (pulses !== 10) begin n_fail++; $display("FAIL nop_en_pulses: got %0d expected 10", pulses); end
        n_checks++;
        if (xs !== 10) begin n_fail++; $display("FAIL nop_exec_strobes: got %0d expected 10", xs); end
        n_checks++;
        if (dec !== 10 || badaddr !== 0) begin
            n_fail++;
            $display("FAIL nop_fetch_addrs: got %0d decodes with %0d bad addrs, expected 10 and 0", dec, badaddr);
        end
        n_checks++;
        if (pc !== 4'd10) begin n_fail++; $display("FAIL nop_pc_final: got %0d expected 10", pc); end
        n_checks++;
        if (both !== 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both); end
    endtask

    task automatic test_wait();
        int bad;
        bad = 0;
        fill(8'h00);
        mem[2] = 8'hD3;
        do_reset();
        Run = 1'b1;
        step(8);
        for (int s = 9; s <= 12; s++) begin
            step(1);
            if (State !== 3'd3 || EnableCount !== 1'b0 || ExecStrobe !== 1'b0 || IR !== 8'hD3) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL wait_exec_hold: got %0d bad EXEC cycles expected 0", bad); end
        step(1);
        n_checks++;
        if (State !== 3'd1 || EnableCount !== 1'b1 || ExecStrobe !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_finish: got st=%0d en=%b xs=%b expected st=1 en=1 xs=1", State, EnableCount, ExecStrobe);
        end
        step(1);
        n_checks++;
        if (ProgAddr !== 4'd3) begin n_fail++; $display("FAIL wait_next_addr: got %0h expected 3", ProgAddr); end
    endtask

    task automatic test_rst_wrap();
        fill(8'h00);
        mem[5] = 8'hE0;
        do_reset();
        Run = 1'b1;
        step(19);
        n_checks++;
        if (ClearCounter !== 1'b1 || EnableCount !== 1'b0 || ExecStrobe !== 1'b1 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_strobes: got clr=%b en=%b xs=%b pc=%0h expected 1 0 1 0",
                     ClearCounter, EnableCount, ExecStrobe, pc);
        end
        step(1);
        n_checks++;
        if (ProgAddr !== 4'd0 || State !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_next_addr: got addr=%0h st=%0d expected 0 2", ProgAddr, State);
        end
        fill(8'h00);
        do_reset();
        Run = 1'b1;
        step(47);
        n_checks++;
        if (ProgAddr !== 4'd15 || State !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_addr15: got addr=%0h st=%0d expected f 2", ProgAddr, State);
        end
        step(3);
        n_checks++;
        if (ProgAddr !== 4'd0 || pc !== 4'd0 || State !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_addr0: got addr=%0h pc=%0h st=%0d expected 0 0 2", ProgAddr, pc, State);
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        fill(8'h00);
        mem[4] = 8'hF0;
        do_reset();
        Run = 1'b1;
        step(16);
        n_checks++;
        if (State !== 3'd4 || Halted !== 1'b1 || ExecStrobe !== 1'b1 || EnableCount !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: got st=%0d h=%b xs=%b en=%b expected 4 1 1 0",
                     State, Halted, ExecStrobe, EnableCount);
        end
        for (int s = 0; s < 5; s++) begin
            step(1);
            if (State !== 3'd4 || Halted !== 1'b1 || EnableCount !== 1'b0 ||
                ClearCounter !== 1'b0 || ExecStrobe !== 1'b0 || pc !== 4'd4) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
        Run = 1'b0;
        step(1);
        n_checks++;
        if (State !== 3'd0 || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_leave: got st=%0d h=%b expected 0 0", State, Halted);
        end
        Run = 1'b1;
        step(1);
        n_checks++;
        if (ClearCounter !== 1'b1 || State !== 3'd1 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_restart: got clr=%b st=%0d pc=%0h expected 1 1 0", ClearCounter, State, pc);
        end
        step(1);
        n_checks++;
        if (ProgAddr !== 4'd0 || State !== 3'd2) begin
            n_fail++;
            $display("FAIL halt_refetch: got addr=%0h st=%0d expected 0 2", ProgAddr, State);
        end
    endtask

    task automatic test_midop();
        fill(8'h00);
        mem[0] = 8'hD9;
        do_reset();
        Run = 1'b1;
        step(4);
        n_checks++;
        if (State !== 3'd3) begin n_fail++; $display("FAIL midop_in_exec: got st=%0d expected 3", State); end
        MainReset = 1'b1;
        step(1);
        n_checks++;
        if (State !== 3'd0 || EnableCount !== 1'b0 || ExecStrobe !== 1'b0 || IR !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_reset: got st=%0d en=%b xs=%b ir=%0h expected 0 0 0 0",
                     State, EnableCount, ExecStrobe, IR);
        end
        MainReset = 1'b0;
        Run = 1'b0;
        step(1);
        n_checks++;
        if (State !== 3'd0 || EnableCount !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_after_reset: got st=%0d en=%b expected 0 0", State, EnableCount);
        end
        fill(8'h00);
        do_reset();
        Run = 1'b1;
        step(2);
        Run = 1'b0;
        step(2);
        n_checks++;
        if (State !== 3'd0 || EnableCount !== 1'b1 || ExecStrobe !== 1'b1) begin
            n_fail++;
            $display("FAIL rundrop_finish: got st=%0d en=%b xs=%b expected 0 1 1", State, EnableCount, ExecStrobe);
        end
        step(1);
        n_checks++;
        if (State !== 3'd0 || EnableCount !== 1'b0 || ClearCounter !== 1'b0 || pc !== 4'd1) begin
            n_fail++;
            $display("FAIL rundrop_idle: got st=%0d en=%b clr=%b pc=%0h expected 0 0 0 1",
                     State, EnableCount, ClearCounter, pc);
        end
    endtask

    initial begin
        MainReset = 1'b1; Run = 1'b0; force_en = 1'b0; force_val = 8'h00;
        fill(8'h00);
        test_reset();
        test_nop_stream();
        test_wait();
        test_rst_wrap();
        test_halt();
        test_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
